// File: rtl/synth_pkg.sv
// Shared synth definitions: note decode, Pythagorean frequency table and envelope states.
package synth_pkg;

  localparam int          NOTE_COUNT = 32;
  localparam int          NOTE_W     = $clog2(NOTE_COUNT);
  localparam int unsigned BASE_FREQ  = 32'd55 << 5;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  typedef logic [NOTE_COUNT-1:0][15:0] freq_table_t;

  // Home row A..; is notes 0-9, top row Q..] is 10-21, bottom row Z../ is 22-31.
  function automatic int note_decode(input logic [8:0] code);
    case (code)
      9'h01C: return 0;   9'h01B: return 1;   9'h023: return 2;   9'h02B: return 3;
      9'h034: return 4;   9'h033: return 5;   9'h03B: return 6;   9'h042: return 7;
      9'h04B: return 8;   9'h04C: return 9;   9'h015: return 10;  9'h01D: return 11;
      9'h024: return 12;  9'h02D: return 13;  9'h02C: return 14;  9'h035: return 15;
      9'h03C: return 16;  9'h043: return 17;  9'h044: return 18;  9'h04D: return 19;
      9'h054: return 20;  9'h05B: return 21;  9'h01A: return 22;  9'h022: return 23;
      9'h021: return 24;  9'h02A: return 25;  9'h032: return 26;  9'h031: return 27;
      9'h03A: return 28;  9'h041: return 29;  9'h049: return 30;  9'h04A: return 31;
      default: return -1;
    endcase
  endfunction

  function automatic freq_table_t build_freq_table();
    freq_table_t t;
    int unsigned num;
    int unsigned den;
    for (int n = 0; n < NOTE_COUNT; n++) begin
      case (n % 12)
        0:  begin num = 32'd1;   den = 32'd1;   end
        1:  begin num = 32'd256; den = 32'd243; end
        2:  begin num = 32'd9;   den = 32'd8;   end
        3:  begin num = 32'd32;  den = 32'd27;  end
        4:  begin num = 32'd81;  den = 32'd64;  end
        5:  begin num = 32'd4;   den = 32'd3;   end
        6:  begin num = 32'd729; den = 32'd512; end
        7:  begin num = 32'd3;   den = 32'd2;   end
        8:  begin num = 32'd128; den = 32'd81;  end
        9:  begin num = 32'd27;  den = 32'd16;  end
        10: begin num = 32'd16;  den = 32'd9;   end
        11: begin num = 32'd243; den = 32'd128; end
        default: begin num = 32'd1; den = 32'd1; end
      endcase
      t[n] = 16'(((BASE_FREQ * num) << (n / 12)) / den);
    end
    return t;
  endfunction

  localparam freq_table_t FREQ_TABLE = build_freq_table();

endpackage

// File: rtl/voice_env.sv
// One voice: envelope state, linear volume ramp and saturating age counter.
module voice_env
  import synth_pkg::*;
#(
  parameter int VOL_W        = 32,
  parameter int VOL_MAX      = 1 << 20,
  parameter int ATTACK_STEP  = 1 << 14,
  parameter int RELEASE_STEP = 1 << 12,
  parameter int AGE_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             retrig_i,
  input  logic             release_i,
  input  logic             tick_i,
  output logic [VOL_W-1:0] vol_o,
  output logic             busy_o,
  output logic [AGE_W-1:0] age_o
);

  localparam logic [VOL_W-1:0] VMAX_C = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] ATK_C  = VOL_W'(ATTACK_STEP);
  localparam logic [VOL_W-1:0] REL_C  = VOL_W'(RELEASE_STEP);

  env_state_t       state_q, state_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             busy_q;

  // An event addressed to this voice takes precedence over a coincident tick.
  always_comb begin
    state_d = state_q;
    vol_d   = vol_q;
    age_d   = age_q;
    if (load_i) begin
      state_d = ENV_ATTACK;
      vol_d   = '0;
      age_d   = '0;
    end else if (retrig_i) begin
      state_d = ENV_ATTACK;
      age_d   = '0;
    end else if (release_i) begin
      if (state_q != ENV_IDLE) state_d = ENV_RELEASE;
      else                     state_d = state_q;
    end else if (tick_i && (state_q != ENV_IDLE)) begin
      if (age_q != '1) age_d = age_q + AGE_W'(1);
      else             age_d = age_q;
      case (state_q)
        ENV_ATTACK: begin
          if (vol_q >= VMAX_C - ATK_C) begin
            vol_d   = VMAX_C;
            state_d = ENV_SUSTAIN;
          end else begin
            vol_d = vol_q + ATK_C;
          end
        end
        ENV_RELEASE: begin
          if (vol_q <= REL_C) begin
            vol_d   = '0;
            state_d = ENV_IDLE;
          end else begin
            vol_d = vol_q - REL_C;
          end
        end
        default: vol_d = vol_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ENV_IDLE;
      vol_q   <= '0;
      age_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vol_q   <= vol_d;
      age_q   <= age_d;
      busy_q  <= (state_d != ENV_IDLE);
    end
  end

  assign vol_o  = vol_q;
  assign busy_o = busy_q;
  assign age_o  = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: PS/2 event detect, note decode, retrigger/idle/steal
// selection and a bank of per-voice envelope generators.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES   = 8,
  parameter int FREQ_W       = 16,
  parameter int VOL_W        = 32,
  parameter int VOL_MAX      = 1 << 20,
  parameter int ATTACK_STEP  = 1 << 14,
  parameter int RELEASE_STEP = 1 << 12,
  parameter int ENV_DIV      = 256,
  parameter int AGE_W        = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [10:0]                       ps2_key,
  output logic [NUM_VOICES-1:0][FREQ_W-1:0] frequencies,
  output logic [NUM_VOICES-1:0][VOL_W-1:0]  voice_volumes,
  output logic [NUM_VOICES-1:0]             voice_busy,
  output logic                              steal_pulse
);

  localparam int DIV_W  = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam int VIDX_W = $clog2(NUM_VOICES);

  logic [10:0]                       key_q;
  logic                              tog_q;
  logic [DIV_W-1:0]                  div_q, div_d;
  logic [NUM_VOICES-1:0][FREQ_W-1:0] freq_q, freq_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] tag_q, tag_d;
  logic                              steal_q, steal_d;

  logic                              tick_s, event_s, press_s, release_s;
  int                                note_int_s;
  logic [NOTE_W-1:0]                 note_s;
  logic [NUM_VOICES-1:0]             busy_s, match_s, load_s, retrig_s, rel_s;
  logic [NUM_VOICES-1:0][AGE_W-1:0]  age_s;
  logic                              idle_found_s;
  logic [VIDX_W-1:0]                 idle_idx_s, old_idx_s;
  logic [AGE_W-1:0]                  old_age_s;

  // The toggle is registered first, so events act one edge after sampling.
  assign event_s    = key_q[10] ^ tog_q;
  assign note_int_s = note_decode(key_q[8:0]);
  assign note_s     = note_int_s[NOTE_W-1:0];
  assign press_s    = event_s && (note_int_s >= 0) && key_q[9];
  assign release_s  = event_s && (note_int_s >= 0) && !key_q[9];

  assign tick_s = (div_q == DIV_W'(ENV_DIV - 1));
  assign div_d  = tick_s ? '0 : div_q + DIV_W'(1);

  // Strict '>' keeps the lowest index on an age tie.
  always_comb begin
    match_s      = '0;
    load_s       = '0;
    retrig_s     = '0;
    rel_s        = '0;
    steal_d      = 1'b0;
    idle_found_s = 1'b0;
    idle_idx_s   = '0;
    old_idx_s    = '0;
    old_age_s    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      match_s[i] = busy_s[i] && (tag_q[i] == note_s);
      if (!busy_s[i] && !idle_found_s) begin
        idle_found_s = 1'b1;
        idle_idx_s   = VIDX_W'(i);
      end
      if (age_s[i] > old_age_s) begin
        old_age_s = age_s[i];
        old_idx_s = VIDX_W'(i);
      end
    end
    if (press_s) begin
      if (|match_s) begin
        retrig_s = match_s;
      end else if (idle_found_s) begin
        load_s[idle_idx_s] = 1'b1;
      end else begin
        load_s[old_idx_s] = 1'b1;
        steal_d           = 1'b1;
      end
    end else if (release_s) begin
      rel_s = match_s;
    end else begin
      steal_d = 1'b0;
    end
  end

  always_comb begin
    freq_d = freq_q;
    tag_d  = tag_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (load_s[i] || retrig_s[i]) begin
        freq_d[i] = FREQ_W'(FREQ_TABLE[note_s]);
        tag_d[i]  = note_s;
      end else begin
        freq_d[i] = freq_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q   <= '0;
      tog_q   <= 1'b0;
      div_q   <= '0;
      freq_q  <= '0;
      tag_q   <= '0;
      steal_q <= 1'b0;
    end else begin
      key_q   <= ps2_key;
      tog_q   <= key_q[10];
      div_q   <= div_d;
      freq_q  <= freq_d;
      tag_q   <= tag_d;
      steal_q <= steal_d;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_env #(
      .VOL_W       (VOL_W),
      .VOL_MAX     (VOL_MAX),
      .ATTACK_STEP (ATTACK_STEP),
      .RELEASE_STEP(RELEASE_STEP),
      .AGE_W       (AGE_W)
    ) u_env (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (load_s[g]),
      .retrig_i (retrig_s[g]),
      .release_i(rel_s[g]),
      .tick_i   (tick_s),
      .vol_o    (voice_volumes[g]),
      .busy_o   (busy_s[g]),
      .age_o    (age_s[g])
    );
  end

  assign frequencies = freq_q;
  assign voice_busy  = busy_s;
  assign steal_pulse = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench: a behavioural voice model predicts every cycle's outputs,
// a monitor pops and compares them against the DUT.
module tb_voice_allocator;

  localparam int NV   = 4;
  localparam int FW   = 16;
  localparam int VW   = 32;
  localparam int DIV  = 3;
  localparam int AW   = 6;
  localparam int VMAX = 1 << 20;
  localparam int AST  = 1 << 14;
  localparam int RST  = 1 << 12;

  localparam int CODES [32] = '{'h1C, 'h1B, 'h23, 'h2B, 'h34, 'h33, 'h3B, 'h42, 'h4B, 'h4C,
                                'h15, 'h1D, 'h24, 'h2D, 'h2C, 'h35, 'h3C, 'h43, 'h44, 'h4D,
                                'h54, 'h5B, 'h1A, 'h22, 'h21, 'h2A, 'h32, 'h31, 'h3A, 'h41,
                                'h49, 'h4A};
  // Position of each semitone on the circle of fifths relative to the root.
  localparam int FIFTHS [12] = '{0, -5, 2, -3, 4, -1, 6, 1, -4, 3, -2, 5};

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [10:0]               ps2_key = '0;
  logic [NV-1:0][FW-1:0]     frequencies;
  logic [NV-1:0][VW-1:0]     voice_volumes;
  logic [NV-1:0]             voice_busy;
  logic                      steal_pulse;

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES(NV), .FREQ_W(FW), .VOL_W(VW), .VOL_MAX(VMAX),
    .ATTACK_STEP(AST), .RELEASE_STEP(RST), .ENV_DIV(DIV), .AGE_W(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .frequencies(frequencies),
    .voice_volumes(voice_volumes), .voice_busy(voice_busy), .steal_pulse(steal_pulse)
  );

  typedef struct packed {
    logic [NV-1:0][FW-1:0] freq;
    logic [NV-1:0][VW-1:0] vol;
    logic [NV-1:0]         busy;
    logic                  steal;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Model state: phase 0 silent, 1 rising, 2 holding, 3 falling.
  int     m_phase [NV];
  longint m_vol   [NV];
  int     m_age   [NV];
  int     m_note  [NV];
  longint m_freq  [NV];
  int     m_edges;
  logic [10:0] m_key;
  logic        m_tog;

  function automatic logic [8:0] code_of(int n);
    return 9'(CODES[n]);
  endfunction

  function automatic int lookup(logic [8:0] c);
    for (int n = 0; n < 32; n++) if (c == code_of(n)) return n;
    return -1;
  endfunction

  function automatic longint pyth_freq(int n);
    longint num = 1;
    longint den = 1;
    int     f   = FIFTHS[n % 12];
    if (f >= 0) begin
      repeat (f) num = num * 3;
      while (num >= 2 * den) den = den * 2;
    end else begin
      repeat (-f) den = den * 3;
      while (num < den) num = num * 2;
    end
    return ((longint'(1760) << (n / 12)) * num) / den;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = 0; m_vol[v] = 0; m_age[v] = 0; m_note[v] = -1; m_freq[v] = 0;
    end
    m_edges = 0;
    m_key   = '0;
    m_tog   = 1'b0;
  endtask

  task automatic model_edge();
    bit    addressed [NV];
    bit    steal, found, tick;
    int    n, target;
    snap_t s;
    steal = 0;
    for (int v = 0; v < NV; v++) addressed[v] = 0;
    m_edges++;
    tick = (m_edges % DIV) == 0;
    if (m_key[10] != m_tog) begin
      n = lookup(m_key[8:0]);
      if (n >= 0 && m_key[9]) begin
        found = 0;
        for (int v = 0; v < NV; v++)
          if (m_phase[v] != 0 && m_note[v] == n) begin
            m_phase[v] = 1; m_age[v] = 0; addressed[v] = 1; found = 1;
          end
        if (!found) begin
          target = -1;
          for (int v = NV - 1; v >= 0; v--) if (m_phase[v] == 0) target = v;
          if (target < 0) begin
            steal  = 1;
            target = 0;
            for (int v = 1; v < NV; v++) if (m_age[v] > m_age[target]) target = v;
          end
          m_vol[target] = 0; m_phase[target] = 1; m_age[target] = 0;
          m_note[target] = n; m_freq[target] = pyth_freq(n); addressed[target] = 1;
        end
      end else if (n >= 0) begin
        for (int v = 0; v < NV; v++)
          if (m_phase[v] != 0 && m_note[v] == n) begin
            m_phase[v] = 3; addressed[v] = 1;
          end
      end
    end
    m_tog = m_key[10];
    m_key = ps2_key;
    if (tick)
      for (int v = 0; v < NV; v++)
        if (!addressed[v] && m_phase[v] != 0) begin
          if (m_age[v] < (1 << AW) - 1) m_age[v]++;
          if (m_phase[v] == 1) begin
            m_vol[v] = m_vol[v] + AST;
            if (m_vol[v] >= VMAX) begin m_vol[v] = VMAX; m_phase[v] = 2; end
          end else if (m_phase[v] == 3) begin
            m_vol[v] = m_vol[v] - RST;
            if (m_vol[v] <= 0) begin m_vol[v] = 0; m_phase[v] = 0; m_note[v] = -1; end
          end
        end
    for (int v = 0; v < NV; v++) begin
      s.freq[v] = FW'(m_freq[v]);
      s.vol[v]  = VW'(m_vol[v]);
      s.busy[v] = (m_phase[v] != 0);
    end
    s.steal = steal;
    exp_q.push_back(s);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_edge();
      end
    end
  end

  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (reset_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (frequencies !== e.freq) begin
          errors++;
          $display("FAIL freq t=%0t got %h want %h", $time, frequencies, e.freq);
        end
        checks++;
        if (voice_volumes !== e.vol) begin
          errors++;
          $display("FAIL vol t=%0t got %h want %h", $time, voice_volumes, e.vol);
        end
        checks++;
        if (voice_busy !== e.busy) begin
          errors++;
          $display("FAIL busy t=%0t got %b want %b", $time, voice_busy, e.busy);
        end
        checks++;
        if (steal_pulse !== e.steal) begin
          errors++;
          $display("FAIL steal t=%0t got %b want %b", $time, steal_pulse, e.steal);
        end
      end
    end
  end

  task automatic check_zero(string nm);
    checks++;
    if (frequencies !== '0 || voice_volumes !== '0 || voice_busy !== '0 || steal_pulse !== 1'b0) begin
      errors++;
      $display("FAIL %s got freq=%h vol=%h busy=%b steal=%b want all zero",
               nm, frequencies, voice_volumes, voice_busy, steal_pulse);
    end
  endtask

  task automatic send(bit press, logic [8:0] code, int gap);
    ps2_key = {~ps2_key[10], press, code};
    repeat (gap + 1) @(negedge clk);
  endtask

  initial begin
    int          r;
    logic [8:0]  c;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_zero("reset_state");
    // single note to full sustain, then three notes with the middle one released
    send(1, code_of(0), 200);
    send(1, code_of(1), 5);
    send(1, code_of(2), 200);
    send(0, code_of(1), 800);
    // fill remaining voices, then steal the oldest
    send(1, code_of(3), 30);
    send(1, code_of(4), 30);
    send(1, code_of(5), 30);
    // steal for note 7, hold to sustain, retrigger, release and retrigger mid-release
    send(1, code_of(7), 200);
    send(1, code_of(7), 10);
    send(0, code_of(7), 20);
    send(1, code_of(7), 20);
    // unmapped codes, then toggles on consecutive cycles
    send(1, 9'h1FF, 2);
    send(0, 9'h11C, 2);
    send(1, code_of(8), 0);
    send(0, code_of(8), 0);
    send(1, code_of(9), 0);
    send(0, code_of(3), 5);
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      c = 9'h100 | 9'($urandom_range(0, 255));
      else if (r == 1) c = code_of(int'($urandom_range(0, 31)));
      else             c = code_of(int'($urandom_range(0, 5)));
      send(bit'($urandom_range(0, 1)), c,
           (k % 50 == 49) ? 800 : ((k % 3 == 0) ? 0 : int'($urandom_range(0, 40))));
    end
    // asynchronous reset in the middle of an attack
    send(1, code_of(10), 10);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_zero("post_reset");
    send(1, code_of(11), 60);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Parametrised polyphonic voice allocator with per-voice linear envelopes. It sits between the PS/2 key decoder and the oscillator/mixer bank, driving one frequency and one volume per voice.
Over the first-generation keyboard block it adds:
- configurable voice count
- same-note retrigger
- oldest-voice stealing when all voices are busy
- attack/release ramps instead of hard on/off volume steps

Parameters:
NUM_VOICES, 8, number of voices; 2..16.
FREQ_W, 16, frequency word width (fixed point, 5 fractional bits).
VOL_W, 32, volume word width.
VOL_MAX, 1<<20, sustain volume.
ATTACK_STEP, 1<<14, volume added per envelope tick in ATTACK.
RELEASE_STEP, 1<<12, volume subtracted per envelope tick in RELEASE.
ENV_DIV, 256, clk cycles per envelope tick; >=1.
AGE_W, 16, width of the saturating per-voice age counter.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_key  in  11  [10] toggles per event, [9] 1=press 0=release, [8:0] extended flag + scancode
frequencies  out  NUM_VOICES x FREQ_W  per-voice oscillator frequency
voice_volumes  out  NUM_VOICES x VOL_W  per-voice envelope level
voice_busy  out  NUM_VOICES  1 when the voice state is not IDLE
steal_pulse  out  1  one-cycle pulse when an event steals a voice

Behaviour:
- Reset: all outputs 0 and all voices IDLE, ages 0, note tags invalid. The toggle-sample register resets to 0; a ps2_key[10] already at 1 after reset therefore counts as one event (documented, intentional). Reset mid-ramp aborts immediately.
- Event detect: an event exists when ps2_key[10] differs from its registered copy.
  - Scancode maps to note 0..NOTE_COUNT-1 through the package decode function; unmapped codes (-1) are ignored.
  - Voice state and outputs update on the clock edge after the toggle is sampled, i.e. 1-cycle latency.
  - Back-to-back toggles on consecutive cycles are each processed.
- Per-voice state: IDLE, ATTACK, SUSTAIN, RELEASE, plus note tag, frequency and age.
- Press, allocation priority:
  1. Any voice with the same note tag that is not IDLE is retriggered: ATTACK, age 0, volume kept (no click).
  2. Otherwise the lowest-index IDLE voice is taken.
  3. Otherwise the voice with the largest age is stolen (tie goes to the lowest index): volume forced to 0, then ATTACK, steal_pulse=1.
  - The assigned voice gets its frequency from the table and its note tag set.
- Release: every non-IDLE voice whose tag matches enters RELEASE. No match means no effect.
- Envelope, on each tick (every ENV_DIV clk; prescaler free-runs from reset):
  - ATTACK: vol += ATTACK_STEP, saturating at VOL_MAX, then SUSTAIN.
  - SUSTAIN: hold.
  - RELEASE: vol -= RELEASE_STEP, floored at 0. On reaching 0 go to IDLE, clear the tag, keep the frequency.
  - A release arriving during ATTACK goes straight to RELEASE from the current level.
- Simultaneous event and tick on the same cycle: the event wins for the addressed voice, whose envelope skips that tick. Other voices tick normally.
- Age: each non-IDLE voice increments its age once per tick, saturating at all-ones. Age is cleared on assignment.
- Arithmetic: unsigned throughout; saturation is checked before the wrap would occur.

Decomposition:
- Package synth_pkg:
  - NOTE_COUNT=32
  - env_state_t enum
  - scancode to note decode function
  - Pythagorean frequency table constant, ground note 55 Hz << 5
  - The existing keyboard block is migrated onto the same package.
- One sub-module voice_env: a single voice's state, volume ramp and age counter, with load, retrigger, release and tick inputs. voice_allocator instantiates NUM_VOICES of them plus the event detector, decoder and priority/steal selector.

Test Plan:
- Reset with ENV_DIV=1, press "A" (note 0) -> voice 0 freq 55<<5=1760 the next cycle; volume reaches VOL_MAX after 64 ticks; voice_busy=0000_0001.
- Press 3 distinct notes, release the second -> only voice 1 ramps down by 4096 per tick to 0, then IDLE with busy bit cleared; voices 0 and 2 stay at VOL_MAX.
- With NUM_VOICES=4, press 5 notes spaced 10 ticks apart -> 5th press steals voice 0 (the oldest), steal_pulse high for exactly 1 cycle, voice 0 freq updated.
- Press note 7, hold to SUSTAIN, press note 7 again -> same voice retriggered to ATTACK from VOL_MAX, no second voice allocated.
- Unmapped scancode press/release, and two toggles on consecutive cycles -> unmapped code gives no state change; both consecutive events are applied in order.
- Assert reset_n low mid-ATTACK -> all volumes and frequencies 0 asynchronously. After release, the first press lands on voice 0.
